// File: rtl/nexys_starship_break_gen.sv
// nexys_starship_break_gen
// Random fault scheduler for the four subsystem repair FSMs (top/bottom/left/right).
// A free-running Galois LFSR picks the delay until the next break, the subsystem
// to break and the repair code. A prescaler turns Clk into game ticks, and a
// difficulty level shortens the random part of the delay as play goes on.
// Optional debug feature: define FORCE_BREAK_EN to add the force_break input,
// which jumps straight from COUNT to FIRE.

module nexys_starship_break_gen #(
    parameter int unsigned TICK_DIV     = 100_000_000,
    parameter int unsigned MIN_INTERVAL = 3,
    parameter int unsigned LEVEL_TICKS  = 20,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic       top_broken,
    input  logic       bottom_broken,
    input  logic       left_broken,
    input  logic       right_broken,
`ifdef FORCE_BREAK_EN
    input  logic       force_break,
`endif
    output logic       TR_random,
    output logic       BR_random,
    output logic       LR_random,
    output logic       RR_random,
    output logic [3:0] random_hex,
    output logic [1:0] level,
    output logic       q_BG_Idle,
    output logic       q_BG_Load,
    output logic       q_BG_Count,
    output logic       q_BG_Fire
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LCNT_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
    localparam int unsigned IV_W    = 5;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [LCNT_W-1:0]  LCNT_MAX  = LCNT_W'(LEVEL_TICKS - 1);
    localparam logic [IV_W-1:0]    MIN_IV    = IV_W'(MIN_INTERVAL);
    localparam logic [15:0]        LFSR_POLY = 16'hB400;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]        SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // One-hot encoding so each state flag is a flop bit of the state register.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_LOAD  = 4'b0010,
        S_COUNT = 4'b0100,
        S_FIRE  = 4'b1000
    } state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next_c;
    logic [PRESC_W-1:0]  presc;
    logic                tick_c;
    logic [LCNT_W-1:0]   lcnt;
    logic [IV_W-1:0]     interval;
    logic [3:0]          shifted_c;
    logic [IV_W-1:0]     load_sum_c;
    logic [IV_W-1:0]     load_iv_c;
    logic [3:0]          broken_c;
    logic [1:0]          target_c;
    logic [1:0]          cand_c;
    logic [1:0]          pick_c;
    logic                found_c;
    logic [3:0]          brk_pulse;
    logic                force_c;

`ifdef FORCE_BREAK_EN
    assign force_c = force_break;
`else
    assign force_c = 1'b0;
`endif

    assign q_BG_Idle  = state[0];
    assign q_BG_Load  = state[1];
    assign q_BG_Count = state[2];
    assign q_BG_Fire  = state[3];

    assign TR_random = brk_pulse[0];
    assign BR_random = brk_pulse[1];
    assign LR_random = brk_pulse[2];
    assign RR_random = brk_pulse[3];

    // Galois right-shift step of the LFSR.
    assign lfsr_next_c = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);

    // Free-running LFSR; only Reset stops it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= lfsr_next_c;
        end
    end

    // Game tick: one cycle per prescaler wrap, never while idle.
    assign tick_c = (state != S_IDLE) && (presc == PRESC_MAX);

    // Prescaler runs in LOAD/COUNT/FIRE and restarts from 0 on each new game.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc <= '0;
        end else if (gameover_ctrl || (state == S_IDLE)) begin
            presc <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Next interval: the random part shrinks as the level rises; never 0.
    assign shifted_c  = lfsr[3:0] >> level;
    assign load_sum_c = MIN_IV + {1'b0, shifted_c};
    assign load_iv_c  = (load_sum_c == '0) ? IV_W'(1) : load_sum_c;

    // Victim selection: first unbroken index starting at the random target.
    assign broken_c = {right_broken, left_broken, bottom_broken, top_broken};
    assign target_c = lfsr[5:4];

    always_comb begin
        found_c = 1'b0;
        pick_c  = 2'd0;
        cand_c  = 2'd0;
        // Walk backwards so the smallest offset from the target wins.
        for (int k = 3; k >= 0; k--) begin
            cand_c = target_c + 2'(k);
            if (!broken_c[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    // Scheduler FSM with registered pulses, repair code and level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            brk_pulse  <= 4'b0000;
            random_hex <= 4'h0;
            level      <= 2'd0;
            lcnt       <= '0;
            interval   <= '0;
        end else begin
            brk_pulse <= 4'b0000;
            if (gameover_ctrl) begin
                // Game over wins over everything, including a pending break.
                state <= S_IDLE;
                level <= 2'd0;
                lcnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        level <= 2'd0;
                        lcnt  <= '0;
                        if (play_flag) begin
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        interval <= load_iv_c;
                        state    <= S_COUNT;
                    end
                    S_COUNT: begin
                        // Difficulty only advances on ticks spent waiting here.
                        if (tick_c) begin
                            if (lcnt == LCNT_MAX) begin
                                lcnt <= '0;
                                if (level != 2'd3) begin
                                    level <= level + 2'd1;
                                end
                            end else begin
                                lcnt <= lcnt + LCNT_W'(1);
                            end
                        end
                        if (force_c) begin
                            state <= S_FIRE;
                        end else if (tick_c) begin
                            if (interval <= IV_W'(1)) begin
                                state <= S_FIRE;
                            end else begin
                                interval <= interval - IV_W'(1);
                            end
                        end
                    end
                    S_FIRE: begin
                        // With everything broken, wait here and rescan each cycle.
                        if (found_c) begin
                            brk_pulse  <= 4'b0001 << pick_c;
                            random_hex <= lfsr[11:8];
                            state      <= S_LOAD;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
